// File: rtl/seq_data_compare_if.sv
// Handshake/bus bundle for seq_data_compare.
// iSigned exists only when COMPARE_SIGNED_EN is defined.
interface seq_data_compare_if #(
  parameter int WIDTH = 32
);
  logic             iValid;
  logic             oReady;
  logic [WIDTH-1:0] iData_a;
  logic [WIDTH-1:0] iData_b;
  logic [2:0]       iData;
`ifdef COMPARE_SIGNED_EN
  logic             iSigned;
`endif
  logic             oValid;
  logic             iReady;
  logic [2:0]       oData;

  modport master (
`ifdef COMPARE_SIGNED_EN
    output iSigned,
`endif
    output iValid, iData_a, iData_b, iData, iReady,
    input  oReady, oValid, oData
  );

  modport slave (
`ifdef COMPARE_SIGNED_EN
    input  iSigned,
`endif
    input  iValid, iData_a, iData_b, iData, iReady,
    output oReady, oValid, oData
  );
endinterface

// File: rtl/seq_data_compare.sv
// Multi-cycle slice-serial magnitude comparator, MSB slice first, early exit
// at the first differing slice. Result {A>B, A<B, A=B}; when every slice is
// equal the latched cascade input iData is forwarded unmodified.
// Optional feature macro: COMPARE_SIGNED_EN (adds iSigned, two's-complement).
// The interface WIDTH must match the module WIDTH.
module seq_data_compare #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic                iClk,
  input  logic                iRst,
  seq_data_compare_if.slave   bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NSLICE - 1);

  generate
    if (WIDTH <= 0 || SLICE <= 0 || (WIDTH % SLICE) != 0) begin : g_param_check
      $error("seq_data_compare: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_cas;
  logic [IDXW-1:0]  r_idx;
  logic             r_oValid;
  logic [2:0]       r_oData;

  logic [WIDTH-1:0]             w_flip;
  logic [NSLICE-1:0][SLICE-1:0] w_a_sl;
  logic [NSLICE-1:0][SLICE-1:0] w_b_sl;
  logic [SLICE-1:0]             w_sa;
  logic [SLICE-1:0]             w_sb;
  logic                         w_gt;
  logic                         w_lt;

  // Signed mode inverts the operand MSB once at latch time; this equals
  // inverting the top-slice MSB in the RUN compare, and lower slices are untouched.
`ifdef COMPARE_SIGNED_EN
  assign w_flip = {bus.iSigned, {(WIDTH-1){1'b0}}};
`else
  assign w_flip = '0;
`endif

  assign w_a_sl = r_a;
  assign w_b_sl = r_b;
  assign w_sa   = w_a_sl[r_idx];
  assign w_sb   = w_b_sl[r_idx];
  assign w_gt   = (w_sa > w_sb);
  assign w_lt   = (w_sa < w_sb);

  assign bus.oReady = (r_state == IDLE);
  assign bus.oValid = r_oValid;
  assign bus.oData  = r_oData;

  // Control FSM: accept, walk slices downward, hold result until consumed.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_oValid <= 1'b0;
      r_oData  <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_cas    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.iValid) begin
            r_a     <= bus.iData_a ^ w_flip;
            r_b     <= bus.iData_b ^ w_flip;
            r_cas   <= bus.iData;
            r_idx   <= IDX_TOP;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_gt || w_lt) begin
            r_oData  <= {w_gt, w_lt, 1'b0};
            r_oValid <= 1'b1;
            r_state  <= DONE;
          end else if (r_idx == '0) begin
            r_oData  <= r_cas;
            r_oValid <= 1'b1;
            r_state  <= DONE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        DONE: begin
          if (bus.iReady) begin
            r_oValid <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
